// File: rtl/logarithm.sv
// Sequential natural-log unit.
// Takes y in unsigned 2.16 format (valid range [1.0, e)) and returns ln(y)
// as an unsigned 0.16 fraction. It uses shift-add multiplicative
// normalisation: greedily multiply a running product p by (1 + 2^-k)
// while it stays <= y, and add ln(1 + 2^-k) to an accumulator each time.
// The start/done handshake matches the exponential block, so the two
// units can be chained for round-trip checking.
// The ln table constants carry 20 fraction bits. GUARD values 1..4 round
// them to nearest. Values above 4 zero-extend them.
module logarithm #(
    parameter int GUARD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  intpart,
    input  logic [15:0] fracpart,
    output logic [15:0] result,
    output logic        done,
    output logic        busy,
    output logic        err
);

    localparam int FW = 16 + GUARD;  // fraction bits of p, acc, table
    localparam int PW = FW + 2;      // p: unsigned 2.FW
    localparam int AW = FW + 1;      // acc: unsigned 1.FW
    localparam int TW = PW + 1;      // trial product, one bit wider than p

    // Rounding/alignment of the 20-fraction-bit table constants to FW bits.
    localparam int DN = (GUARD < 4) ? (4 - GUARD) : 0;
    localparam int UP = (GUARD > 4) ? (GUARD - 4) : 0;
    localparam logic [20:0] TBL_HALF = (21'd1 << DN) >> 1;

    localparam logic [PW-1:0] ONE_P    = PW'(1) << FW;
    localparam logic [AW:0]   ACC_HALF = (AW + 1)'(1) << (GUARD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ITER  = 2'd2,
        ROUND = 2'd3
    } state_t;

    // ln(1 + 2^-k), k = 0..16, as 0.20 values rounded to nearest,
    // then aligned to FW fraction bits.
    function automatic logic [FW-1:0] ln_table(input logic [4:0] idx);
        logic [19:0] base;
        logic [20:0] rnd;
        case (idx)
            5'd0:    base = 20'hB1721;
            5'd1:    base = 20'h67CC9;
            5'd2:    base = 20'h391FF;
            5'd3:    base = 20'h1E270;
            5'd4:    base = 20'h0F852;
            5'd5:    base = 20'h07E0A;
            5'd6:    base = 20'h03F81;
            5'd7:    base = 20'h01FE0;
            5'd8:    base = 20'h00FF8;
            5'd9:    base = 20'h007FE;
            5'd10:   base = 20'h00400;
            5'd11:   base = 20'h00200;
            5'd12:   base = 20'h00100;
            5'd13:   base = 20'h00080;
            5'd14:   base = 20'h00040;
            5'd15:   base = 20'h00020;
            5'd16:   base = 20'h00010;
            default: base = 20'h00000;
        endcase
        rnd = {1'b0, base} + TBL_HALF;
        ln_table = FW'(rnd >> DN) << UP;
    endfunction

    state_t          state_r, state_s;
    logic [17:0]     y_r, y_s;
    logic [PW-1:0]   p_r, p_s;
    logic [AW-1:0]   acc_r, acc_s;
    logic [4:0]      k_r, k_s;
    logic [15:0]     result_r, result_s;
    logic            done_r, done_s;
    logic            busy_r, busy_s;
    logic            err_r, err_s;

    logic [TW-1:0]   t_s;
    logic [TW-1:0]   y_ext_s;
    logic [AW:0]     acc_round_s;
    logic [17:0]     r_s;

    // Datapath helpers: trial product, aligned operand, rounded accumulator.
    always_comb begin
        t_s         = TW'(p_r) + TW'(p_r >> k_r);
        y_ext_s     = TW'(y_r) << GUARD;
        acc_round_s = {1'b0, acc_r} + ACC_HALF;
        r_s         = 18'(acc_round_s >> GUARD);
    end

    // Next-state and next-output logic for the IDLE/LOAD/ITER/ROUND sequence.
    always_comb begin
        state_s  = state_r;
        y_s      = y_r;
        p_s      = p_r;
        acc_s    = acc_r;
        k_s      = k_r;
        result_s = result_r;
        done_s   = 1'b0;
        busy_s   = busy_r;
        err_s    = err_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    y_s     = {intpart, fracpart};
                    busy_s  = 1'b1;
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (y_r < 18'h10000) begin
                    result_s = 16'h0000;
                    err_s    = 1'b1;
                    done_s   = 1'b1;
                    busy_s   = 1'b0;
                    state_s  = IDLE;
                end else begin
                    p_s     = ONE_P;
                    acc_s   = {AW{1'b0}};
                    k_s     = 5'd0;
                    err_s   = 1'b0;
                    state_s = ITER;
                end
            end
            ITER: begin
                if (t_s <= y_ext_s) begin
                    p_s   = PW'(t_s);
                    acc_s = acc_r + AW'(ln_table(k_r));
                end else begin
                    p_s   = p_r;
                    acc_s = acc_r;
                end
                k_s = k_r + 5'd1;
                if (k_r == 5'd16) begin
                    state_s = ROUND;
                end else begin
                    state_s = ITER;
                end
            end
            ROUND: begin
                // Anything that rounds to 1.0 or more saturates (y near or beyond e).
                if (r_s[17:16] != 2'b00) begin
                    result_s = 16'hFFFF;
                end else begin
                    result_s = r_s[15:0];
                end
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            y_r      <= 18'h00000;
            p_r      <= {PW{1'b0}};
            acc_r    <= {AW{1'b0}};
            k_r      <= 5'd0;
            result_r <= 16'h0000;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            y_r      <= y_s;
            p_r      <= p_s;
            acc_r    <= acc_s;
            k_r      <= k_s;
            result_r <= result_s;
            done_r   <= done_s;
            busy_r   <= busy_s;
            err_r    <= err_s;
        end
    end

    assign result = result_r;
    assign done   = done_r;
    assign busy   = busy_r;
    assign err    = err_r;

endmodule

// File: tb/tb_logarithm.sv
// Scoreboard bench for the logarithm unit: the stimulus pushes expected
// responses, and a monitor pops and compares them whenever done pulses.
module tb_logarithm;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  intpart;
    logic [15:0] fracpart;
    logic [15:0] result;
    logic        done;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] res;
        int          tol;
        logic        er;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [17:0] y;
        logic [15:0] res;
        int          tol;
        logic        er;
        int          lat;
    } vec_t;

    logarithm #(.GUARD(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .intpart  (intpart),
        .fracpart (fracpart),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req, input longint tol);
        longint diff;
        checks++;
        diff = act - req;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h tol=%0d", name, act, req, tol);
        end
    endtask

    // Drives one operation once the unit is idle. When push is set, the
    // expected response is queued with the accept cycle.
    task automatic issue(input logic [17:0] y, input logic [15:0] res, input int tol,
                         input logic er, input int lat, input bit push);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout busy stuck high after %0d cycles", n);
        end
        start = 1'b1;
        {intpart, fracpart} = y;
        @(posedge clk); #1;
        if (push) sb_q.push_back('{res, tol, er, lat, cyc});
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout no done after %0d cycles", n);
        end
    endtask

    // Monitor: pop and compare on every done pulse, count busy cycles.
    initial begin : monitor
        exp_t e;
        int   busy_cnt;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) busy_cnt = 0;
            else if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                check("busy_low_on_done", busy, 0, 0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual result=%0h required no done", result);
                end else begin
                    e = sb_q.pop_front();
                    check("result", result, e.res, e.tol);
                    check("err", err, e.er, 0);
                    check("latency", cyc - e.acc, e.lat, 0);
                    check("busy_cycles", busy_cnt, e.lat, 0);
                end
                busy_cnt = 0;
                @(negedge clk);
                if (rst === 1'b1) busy_cnt = 0;
                else if (busy === 1'b1) busy_cnt++;
                check("done_one_cycle", done, 0, 0);
                if (e.lat > 0) check("result_hold", result, e.res, e.tol);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        vec_t vecs[7];
        int   n;
        logic [17:0] y;
        real  lnv;
        int   expv;

        vecs[0] = '{18'h20000, 16'hB172, 2, 1'b0, 19};
        vecs[1] = '{18'h18000, 16'h67CC, 2, 1'b0, 19};
        vecs[2] = '{18'h0FFFF, 16'h0000, 0, 1'b1, 1};
        vecs[3] = '{18'h10000, 16'h0000, 0, 1'b0, 19};
        vecs[4] = '{18'h2B7E1, 16'hFFFF, 0, 1'b0, 19};
        vecs[5] = '{18'h3FFFF, 16'hFFFF, 0, 1'b0, 19};
        vecs[6] = '{18'h00000, 16'h0000, 0, 1'b1, 1};

        // Reset with start held high.
        rst = 1'b1;
        start = 1'b1;
        intpart = 2'd1;
        fracpart = 16'h0000;
        @(posedge clk); @(posedge clk); #1;
        check("rst_result", result, 0, 0);
        check("rst_done", done, 0, 0);
        check("rst_busy", busy, 0, 0);
        check("rst_err", err, 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        sb_q.push_back('{16'h0000, 0, 1'b0, 19, cyc});
        start = 1'b0;

        // Directed vectors.
        foreach (vecs[i]) issue(vecs[i].y, vecs[i].res, vecs[i].tol, vecs[i].er, vecs[i].lat, 1'b1);

        // A start pulse mid-operation is ignored.
        issue(18'h20000, 16'hB172, 2, 1'b0, 19, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        {intpart, fracpart} = 18'h18000;
        @(posedge clk); #1;
        start = 1'b0;

        // A start on the done cycle is accepted immediately.
        wait_done();
        issue(18'h18000, 16'h67CC, 2, 1'b0, 19, 1'b1);

        // A reset at cycle 10 of an operation discards it and clears the outputs.
        issue(18'h20000, 16'h0000, 0, 1'b0, 19, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_result", result, 0, 0);
        check("midrst_done", done, 0, 0);
        check("midrst_busy", busy, 0, 0);
        check("midrst_err", err, 0, 0);
        repeat (25) @(posedge clk);
        #1;

        // Round trip over a sweep of exponential outputs.
        for (int i = 0; i < 20; i++) begin
            y = 18'($urandom_range(32'h2B7E0, 32'h10000));
            lnv = $ln(real'(y) / 65536.0) * 65536.0;
            expv = int'(lnv + 0.5);
            if (expv > 65535) expv = 65535;
            issue(y, 16'(expv), 2, 1'b0, 19, 1'b1);
        end

        // Drain the scoreboard.
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
